// File: rtl/video_timing_controller.sv
// video_timing_controller
//   Raster timing generator for the DVI pixel pipeline. Produces de/hs/vs and
//   the x/y position, plus start-of-frame and end-of-active-line strobes.
//   A level enable starts the raster; dropping it lets the current frame
//   finish before the generator parks in IDLE, so no frame is ever truncated
//   by the enable (only by reset).
//
//   The enable is captured in a register before it reaches the state machine.
//   This gives the documented start latency: enable seen at edge N, counters
//   at (0,0) in RUN after edge N+1, first pixel on the outputs after edge N+2.
//
//   Optional build macro: VTC_LINE_IRQ_EN
//     Adds i_irq_line / o_line_irq, a one-cycle strobe at x = 0 of a chosen
//     line. The line number is re-sampled only at frame wrap (or while idle).
//
//   Every output is registered from the counter stage.

module video_timing_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_en,
`ifdef VTC_LINE_IRQ_EN
  input  logic [10:0] i_irq_line,
  output logic        o_line_irq,
`endif
  output logic        o_de,
  output logic        o_hs,
  output logic        o_vs,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_running
);

  // ---------------------------------------------------------------------------
  // Geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries are held in 12 bits so that a boundary equal to 2048
  // (a total of exactly 2048) is still representable in the compares.
  localparam logic [11:0] H_ACT_L    = 12'(H_ACTIVE);
  localparam logic [11:0] H_EOL_L    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_SYNC_B_L = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_E_L = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_L   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT_L    = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_B_L = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_E_L = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_L   = 12'(V_TOTAL - 1);

  localparam logic HS_ACT  = (HS_POL != 0);
  localparam logic HS_IDLE = ~HS_ACT;
  localparam logic VS_ACT  = (VS_POL != 0);
  localparam logic VS_IDLE = ~VS_ACT;

  // Totals beyond the 11-bit counter range cannot be generated.
  if ((H_TOTAL > 2048) || (V_TOTAL > 2048)) begin : g_total_check
    $error("video_timing_controller: H_TOTAL or V_TOTAL exceeds 2048");
  end

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_r;
  logic [1:0]  state_s;
  logic        en_r;
  logic [10:0] h_cnt_r;
  logic [10:0] v_cnt_r;
  logic [10:0] h_cnt_s;
  logic [10:0] v_cnt_s;
  logic [11:0] h_ext_s;
  logic [11:0] v_ext_s;
  logic        active_s;
  logic        h_last_s;
  logic        v_last_s;
  logic        frame_end_s;

  assign h_ext_s     = {1'b0, h_cnt_r};
  assign v_ext_s     = {1'b0, v_cnt_r};
  assign active_s    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign h_last_s    = (h_ext_s == H_LAST_L);
  assign v_last_s    = (v_ext_s == V_LAST_L);
  assign frame_end_s = h_last_s && v_last_s;

  // Enable capture register, feeding the state machine.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      en_r <= 1'b0;
    end else begin
      en_r <= i_en;
    end
  end

  // Next-state logic: stopping is only ever allowed on the last pixel of a frame.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en_r) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (en_r) begin
          state_s = ST_RUN;
        end else if (frame_end_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (en_r) begin
          state_s = ST_RUN;
        end else if (frame_end_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next-counter logic: raster scan while active, parked at the origin otherwise.
  always_comb begin
    h_cnt_s = 11'd0;
    v_cnt_s = 11'd0;
    if (active_s) begin
      if (h_last_s) begin
        h_cnt_s = 11'd0;
        if (v_last_s) begin
          v_cnt_s = 11'd0;
        end else begin
          v_cnt_s = v_cnt_r + 11'd1;
        end
      end else begin
        h_cnt_s = h_cnt_r + 11'd1;
        v_cnt_s = v_cnt_r;
      end
    end else begin
      h_cnt_s = 11'd0;
      v_cnt_s = 11'd0;
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= ST_IDLE;
      h_cnt_r <= 11'd0;
      v_cnt_r <= 11'd0;
    end else begin
      state_r <= state_s;
      h_cnt_r <= h_cnt_s;
      v_cnt_r <= v_cnt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode, one register stage after the counters
  // ---------------------------------------------------------------------------
  logic de_s;
  logic hs_on_s;
  logic vs_on_s;
  logic sof_s;
  logic eol_s;

  assign de_s    = (h_ext_s < H_ACT_L) && (v_ext_s < V_ACT_L);
  assign hs_on_s = (h_ext_s >= H_SYNC_B_L) && (h_ext_s < H_SYNC_E_L);
  assign vs_on_s = (v_ext_s >= V_SYNC_B_L) && (v_ext_s < V_SYNC_E_L);
  assign sof_s   = (h_cnt_r == 11'd0) && (v_cnt_r == 11'd0);
  assign eol_s   = (h_ext_s == H_EOL_L) && (v_ext_s < V_ACT_L);

  // Registered timing outputs; idle values whenever the raster is stopped.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_de      <= 1'b0;
      o_hs      <= HS_IDLE;
      o_vs      <= VS_IDLE;
      o_x       <= 11'd0;
      o_y       <= 11'd0;
      o_sof     <= 1'b0;
      o_eol     <= 1'b0;
      o_running <= 1'b0;
    end else if (active_s) begin
      o_de      <= de_s;
      o_hs      <= hs_on_s ? HS_ACT : HS_IDLE;
      o_vs      <= vs_on_s ? VS_ACT : VS_IDLE;
      o_x       <= h_cnt_r;
      o_y       <= v_cnt_r;
      o_sof     <= sof_s;
      o_eol     <= eol_s;
      o_running <= 1'b1;
    end else begin
      o_de      <= 1'b0;
      o_hs      <= HS_IDLE;
      o_vs      <= VS_IDLE;
      o_x       <= 11'd0;
      o_y       <= 11'd0;
      o_sof     <= 1'b0;
      o_eol     <= 1'b0;
      o_running <= 1'b0;
    end
  end

`ifdef VTC_LINE_IRQ_EN
  // ---------------------------------------------------------------------------
  // Line interrupt
  // ---------------------------------------------------------------------------
  logic [10:0] irq_line_r;

  // Capture the target line while idle or at frame wrap, so it changes per frame.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      irq_line_r <= 11'h7FF;
    end else if (!active_s || frame_end_s) begin
      irq_line_r <= i_irq_line;
    end else begin
      irq_line_r <= irq_line_r;
    end
  end

  // One-cycle strobe aligned with the other outputs at x = 0 of the target line.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_line_irq <= 1'b0;
    end else if (active_s) begin
      o_line_irq <= (h_cnt_r == 11'd0) && (v_cnt_r == irq_line_r);
    end else begin
      o_line_irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_controller.sv
// Testbench for video_timing_controller.
// A reduced raster (31 x 21 clocks) keeps whole frames short. A pixel-index
// model predicts every output on every cycle; directed sections pin the model
// with hand-computed geometry numbers, then a randomized enable/reset phase runs.

module tb_video_timing_controller;

  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 5;
  localparam int VA = 12, VFP = 2, VSW = 3, VBP = 4;
  localparam int HSP = 0, VSP = 1;
  localparam int HT = HA + HFP + HSW + HBP;   // 31
  localparam int VT = VA + VFP + VSW + VBP;   // 21
  localparam int FRAME = HT * VT;             // 651

  logic        clk;
  logic        rstn;
  logic        en;
  logic        de, hs, vs, sof, eol, running;
  logic [10:0] x, y;
`ifdef VTC_LINE_IRQ_EN
  logic [10:0] irq_line;
  logic        line_irq;
`endif

  video_timing_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_en(en),
`ifdef VTC_LINE_IRQ_EN
    .i_irq_line(irq_line),
    .o_line_irq(line_irq),
`endif
    .o_de(de),
    .o_hs(hs),
    .o_vs(vs),
    .o_x(x),
    .o_y(y),
    .o_sof(sof),
    .o_eol(eol),
    .o_running(running)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Reference model: the raster is a pixel index into the frame while running.
  // ---------------------------------------------------------------------------
  bit m_run;
  int m_pos;
  bit m_en_seen;
  int m_irq_line;
  int e_de, e_hs, e_vs, e_x, e_y, e_sof, e_eol, e_run, e_irq;

  task automatic set_idle();
    e_de = 0; e_hs = (HSP != 0) ? 0 : 1; e_vs = (VSP != 0) ? 0 : 1;
    e_x = 0; e_y = 0; e_sof = 0; e_eol = 0; e_run = 0; e_irq = 0;
  endtask

  task automatic set_pixel(input int p);
    int px, py;
    px = p % HT;
    py = p / HT;
    e_x   = px;
    e_y   = py;
    e_de  = (px < HA && py < VA) ? 1 : 0;
    e_hs  = (px >= HA + HFP && px < HA + HFP + HSW) ? HSP : 1 - HSP;
    e_vs  = (py >= VA + VFP && py < VA + VFP + VSW) ? VSP : 1 - VSP;
    e_sof = (p == 0) ? 1 : 0;
    e_eol = (px == HA - 1 && py < VA) ? 1 : 0;
    e_run = 1;
    e_irq = (px == 0 && py == m_irq_line) ? 1 : 0;
  endtask

  initial begin
    m_run = 0; m_pos = 0; m_en_seen = 0; m_irq_line = 2047;
    set_idle();
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_run = 0; m_pos = 0; m_en_seen = 0; m_irq_line = 2047;
        set_idle();
      end else begin
        if (m_run) set_pixel(m_pos);
        else set_idle();
        if (m_run) begin
          if (m_pos == FRAME - 1) begin
            if (!m_en_seen) m_run = 0;
            m_pos = 0;
`ifdef VTC_LINE_IRQ_EN
            m_irq_line = int'(irq_line);
`endif
          end else begin
            m_pos++;
          end
        end else begin
`ifdef VTC_LINE_IRQ_EN
          m_irq_line = int'(irq_line);
`endif
          if (m_en_seen) begin
            m_run = 1;
            m_pos = 0;
          end
        end
        m_en_seen = en;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      set_idle();
    end
    chk("de", int'(de), e_de);
    chk("hs", int'(hs), e_hs);
    chk("vs", int'(vs), e_vs);
    chk("x", int'(x), e_x);
    chk("y", int'(y), e_y);
    chk("sof", int'(sof), e_sof);
    chk("eol", int'(eol), e_eol);
    chk("running", int'(running), e_run);
`ifdef VTC_LINE_IRQ_EN
    chk("line_irq", int'(line_irq), e_irq);
`endif
  end

  // Wait (bounded) until the DUT shows pixel (wx, wy) while running.
  task automatic wait_xy(input int wx, input int wy, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (running && int'(x) == wx && int'(y) == wy) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk(name, int'(found), 1);
  endtask

  // Wait (bounded) for a start-of-frame strobe; returns the cycle stamp.
  task automatic wait_sof(output int t, input string name);
    bit found;
    found = 0;
    t = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (sof) begin
        found = 1;
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    chk(name, int'(found), 1);
  endtask

  int de_cnt, vs_cnt, eol_cnt, sof_cnt, sof_t0, sof_t1;
  int hs_run, hs_width, hs_x0;
  bit hs_done, hs_seen;
  int last_x, last_y, t_a, t_b;

  initial begin
    rstn = 1'b0;
    en   = 1'b0;
`ifdef VTC_LINE_IRQ_EN
    irq_line = 11'd5;
`endif
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Idle with enable low: the compare process checks every cycle.
    repeat (200) @(negedge clk);
    chk("idle_hs", int'(hs), 1);
    chk("idle_vs", int'(vs), 0);
    chk("idle_running", int'(running), 0);

    // Start latency: enable sampled at edge N, first pixel after edge N+2.
    en = 1'b1;
    @(negedge clk);
    chk("start_n_sof", int'(sof), 0);
    @(negedge clk);
    chk("start_n1_running", int'(running), 0);
    @(negedge clk);
    chk("start_n2_sof", int'(sof), 1);
    chk("start_n2_de", int'(de), 1);
    chk("start_n2_xy", int'(x) + 100 * int'(y), 0);

    // Two full frames of geometry statistics.
    de_cnt = 0; vs_cnt = 0; eol_cnt = 0; sof_cnt = 0; sof_t0 = 0; sof_t1 = 0;
    hs_run = 0; hs_width = 0; hs_x0 = -1; hs_done = 0; hs_seen = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (de) de_cnt++;
      if (vs) vs_cnt++;
      if (eol) begin
        eol_cnt++;
        chk("eol_x", int'(x), HA - 1);
      end
      if (sof) begin
        if (sof_cnt == 0) sof_t0 = i;
        else sof_t1 = i;
        sof_cnt++;
      end
      if (!hs) begin
        if (!hs_seen) begin
          hs_seen = 1;
          hs_x0 = int'(x);
        end
        hs_run++;
      end else if (hs_run > 0 && !hs_done) begin
        hs_done = 1;
        hs_width = hs_run;
      end
      @(negedge clk);
    end
    chk("frame_de_cycles", de_cnt, 2 * 192);
    chk("frame_vs_cycles", vs_cnt, 2 * 93);
    chk("frame_eol_count", eol_cnt, 2 * 12);
    chk("frame_sof_count", sof_cnt, 2);
    chk("sof_period", sof_t1 - sof_t0, 651);
    chk("hs_start_x", hs_x0, 20);
    chk("hs_width", hs_width, 6);

    // Graceful stop: drop enable mid-frame, timing runs to the frame end.
    wait_xy(5, 8, "stop_reach_5_8");
    en = 1'b0;
    last_x = -1; last_y = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (!running) break;
      last_x = int'(x);
      last_y = int'(y);
      @(negedge clk);
    end
    chk("stop_running_low", int'(running), 0);
    chk("stop_last_x", last_x, 30);
    chk("stop_last_y", last_y, 20);

    // Re-enable during drain: no gap between frames.
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_sof(t_a, "reen_first_sof");
    @(negedge clk);
    wait_xy(0, 3, "reen_reach_y3");
    en = 1'b0;
    wait_xy(0, 10, "reen_reach_y10");
    en = 1'b1;
    wait_sof(t_b, "reen_next_sof");
    chk("reen_sof_period", t_b - t_a, 651);

`ifdef VTC_LINE_IRQ_EN
    irq_line = 11'd4;
    repeat (2 * FRAME) @(negedge clk);
    irq_line = 11'd600;
    repeat (2 * FRAME) @(negedge clk);
`endif

    // Randomized enable toggling with occasional mid-frame resets.
    for (int i = 0; i < 16000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 4999) == 0) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
`ifdef VTC_LINE_IRQ_EN
      if ($urandom_range(0, 999) == 0) irq_line = 11'($urandom_range(0, 30));
`endif
    end

    en = 1'b0;
    repeat (2 * FRAME + 5) @(negedge clk);
    chk("final_idle_running", int'(running), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
